// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage issue controller: opcode encodings,
// datapath widths, FSM state encoding and the known-opcode decoder.
package alu_pkg;

    localparam int OP_W   = 7;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_ADD = 7'h00;
    localparam logic [OP_W-1:0] OP_SUB = 7'h01;
    localparam logic [OP_W-1:0] OP_MUL = 7'h02;
    localparam logic [OP_W-1:0] OP_LDB = 7'h10;
    localparam logic [OP_W-1:0] OP_LDW = 7'h11;
    localparam logic [OP_W-1:0] OP_STB = 7'h12;
    localparam logic [OP_W-1:0] OP_STW = 7'h13;
    localparam logic [OP_W-1:0] OP_MOV = 7'h14;
    localparam logic [OP_W-1:0] OP_BEQ = 7'h30;
    localparam logic [OP_W-1:0] OP_JMP = 7'h31;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    function automatic logic is_known_op(input logic [OP_W-1:0] op);
        logic known;
        case (op)
            OP_ADD, OP_SUB, OP_MUL,
            OP_LDB, OP_LDW, OP_STB, OP_STW,
            OP_MOV, OP_BEQ, OP_JMP: known = 1'b1;
            default:                known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that paces multi-cycle multiplies; zero flags the
// final wait cycle. Decrement saturates at zero.
module alu_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer in front of the combinational ALU; holds MUL operands
// for MUL_LAT cycles. Optional counters enabled by ALU_ISSUE_PERF_EN.
//
// state       | meaning
// ST_IDLE     | accepting one op per cycle, ALU fed straight from decode
// ST_MUL_WAIT | multiplier busy, ALU fed from held regs, decode stalled
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 5,   // legal range 1..15
    parameter int RD_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic [RD_W-1:0]   in_rd,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_w,
    input  logic              alu_z,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_w,
    output logic              out_z,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_err,
    output logic              stall
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam int LOAD_INT = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_INT);
    localparam bit MUL_MULTI = (MUL_LAT > 1);

    state_t            state;
    logic [OP_W-1:0]   hold_op;
    logic [DATA_W-1:0] hold_x;
    logic [DATA_W-1:0] hold_y;
    logic [RD_W-1:0]   hold_rd;

    logic accept;
    logic is_mul;
    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;

    assign in_ready = (state == ST_IDLE);
    assign stall    = ~in_ready;
    assign accept   = in_valid & ~flush & in_ready;
    assign is_mul   = (in_op == OP_MUL);
    assign cnt_load = accept & is_mul & MUL_MULTI;
    assign cnt_en   = (state == ST_MUL_WAIT);

    assign alu_op = in_ready ? in_op : hold_op;
    assign alu_x  = in_ready ? in_x  : hold_x;
    assign alu_y  = in_ready ? in_y  : hold_y;

    alu_lat_counter #(
        .W(CNT_W)
    ) u_lat_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (CNT_LOAD),
        .en    (cnt_en),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_op   <= '0;
            hold_x    <= '0;
            hold_y    <= '0;
            hold_rd   <= '0;
            out_valid <= 1'b0;
            out_w     <= '0;
            out_z     <= 1'b0;
            out_rd    <= '0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul && MUL_MULTI) begin
                            hold_op <= in_op;
                            hold_x  <= in_x;
                            hold_y  <= in_y;
                            hold_rd <= in_rd;
                            state   <= ST_MUL_WAIT;
                        end else begin
                            out_valid <= 1'b1;
                            out_w     <= alu_w;
                            out_z     <= alu_z;
                            out_rd    <= in_rd;
                            out_err   <= ~is_known_op(in_op);
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    // A flush kills the multiply even on its final cycle.
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (cnt_zero) begin
                        out_valid <= 1'b1;
                        out_w     <= alu_w;
                        out_z     <= alu_z;
                        out_rd    <= hold_rd;
                        out_err   <= ~is_known_op(hold_op);
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (in_valid && !in_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: scoreboard of expected completions
// plus a second instance built with MUL_LAT=1.
module tb_alu_issue_ctrl;

    localparam int LAT0 = 5;

    typedef struct {
        logic [31:0] w;
        logic        z;
        logic [4:0]  rd;
        logic        err;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        in_valid, in_ready;
    logic [6:0]  in_op, alu_op;
    logic [31:0] in_x, in_y, alu_x, alu_y, alu_w, out_w;
    logic [4:0]  in_rd, out_rd;
    logic        alu_z, out_valid, out_z, out_err, stall;

    logic        v1, rdy1;
    logic [6:0]  op1, aop1;
    logic [31:0] x1, y1, ax1, ay1, aw1, o1_w;
    logic [4:0]  rd1, o1_rd;
    logic        az1, o1_valid, o1_z, o1_err, stall1;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops, perf_stall, perf_ops1, perf_stall1;
`endif

    sb_t sb[$];
    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    function automatic logic ref_known(input logic [6:0] op);
        case (op)
            7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h30, 7'h31: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Bench-side ALU; ops that leave w stale return a recognisable constant.
    function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            7'h00, 7'h10, 7'h11, 7'h12, 7'h13: return x + y;
            7'h01:   return x - y;
            7'h02:   return x * y;
            7'h14:   return y;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_w = ref_alu(alu_op, alu_x, alu_y);
        alu_z = (alu_x == alu_y);
        aw1   = ref_alu(aop1, ax1, ay1);
        az1   = (ax1 == ay1);
    end

    alu_issue_ctrl #(.MUL_LAT(LAT0), .RD_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_rd(in_rd),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_w(alu_w), .alu_z(alu_z),
        .out_valid(out_valid), .out_w(out_w), .out_z(out_z), .out_rd(out_rd), .out_err(out_err),
        .stall(stall)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    alu_issue_ctrl #(.MUL_LAT(1), .RD_W(5)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(v1), .in_ready(rdy1), .in_op(op1), .in_x(x1), .in_y(y1), .in_rd(rd1),
        .alu_op(aop1), .alu_x(ax1), .alu_y(ay1), .alu_w(aw1), .alu_z(az1),
        .out_valid(o1_valid), .out_w(o1_w), .out_z(o1_z), .out_rd(o1_rd), .out_err(o1_err),
        .stall(stall1)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_ops(perf_ops1), .perf_stall(perf_stall1)
`endif
    );

    // Advance one cycle and retire any completion against the scoreboard.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out_valid=1 at cycle %0d, required no completion", cyc);
            end else begin
                e = sb.pop_front();
                if ({out_w, out_z, out_rd, out_err} !== {e.w, e.z, e.rd, e.err} || cyc != e.due) begin
                    errors++;
                    $display("FAIL sb_data: cycle %0d w=%h z=%b rd=%0d err=%b, required cycle %0d w=%h z=%b rd=%0d err=%b",
                             cyc, out_w, out_z, out_rd, out_err, e.due, e.w, e.z, e.rd, e.err);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL sb_missing: out_valid=%b at cycle %0d, required 1 (due %0d)", out_valid, cyc, sb[0].due);
            void'(sb.pop_front());
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] rd, input logic fl, input logic acc);
        sb_t e;
        in_valid = v; in_op = op; in_x = x; in_y = y; in_rd = rd; flush = fl;
        if (acc) begin
            e.w = ref_alu(op, x, y); e.z = (x == y); e.rd = rd; e.err = !ref_known(op);
            e.due = cyc + ((op == 7'h02) ? LAT0 : 1);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        v1 = 1'b0; op1 = '0; x1 = '0; y1 = '0; rd1 = '0;
        #3;
        checks++;
        if ({out_valid, out_w, out_z, out_rd, out_err, in_ready, stall} !== {1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: v=%b w=%h z=%b rd=%0d err=%b rdy=%b stall=%b, required zeros with rdy=1",
                     out_valid, out_w, out_z, out_rd, out_err, in_ready, stall);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_sub();
        drive(1'b1, 7'h00, 32'd7, 32'd5, 5'd3, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_w !== 32'd12 || out_rd !== 5'd3) begin
            errors++;
            $display("FAIL add_7_5: v=%b w=%h rd=%0d, required v=1 w=0000000c rd=3", out_valid, out_w, out_rd);
        end
        drive(1'b1, 7'h01, 32'd3, 32'd5, 5'd4, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_w !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sub_3_5: v=%b w=%h, required v=1 w=fffffffe", out_valid, out_w);
        end
        drive(1'b1, 7'h14, 32'd1, 32'h1234_5678, 5'd5, 1'b0, 1'b1); tick();
        drive(1'b1, 7'h11, 32'h100, 32'h8, 5'd6, 1'b0, 1'b1); tick();
        drive(1'b1, 7'h01, 32'h0, 32'h1, 5'd7, 1'b0, 1'b1); tick();
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_w !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL hold_idle: v=%b w=%h, required v=0 w=ffffffff held", out_valid, out_w);
        end
    endtask

    task automatic test_mul();
        drive(1'b1, 7'h02, 32'd6, 32'd7, 5'd9, 1'b0, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("FAIL mul_stall_t%0d: rdy=%b stall=%b, required rdy=0 stall=1", i, in_ready, stall);
            end
            drive(1'b1, 7'h00, 32'd100, 32'd100, 5'd1, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_w !== 32'd42 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_done_t5: v=%b w=%h rdy=%b, required v=1 w=0000002a rdy=1", out_valid, out_w, in_ready);
        end
        drive(1'b1, 7'h00, 32'd1, 32'd2, 5'd2, 1'b0, 1'b1);
        tick();
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_beq();
        drive(1'b1, 7'h30, 32'd9, 32'd9, 5'd10, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_z !== 1'b1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL beq_equal: v=%b z=%b err=%b, required v=1 z=1 err=0", out_valid, out_z, out_err);
        end
        drive(1'b1, 7'h30, 32'd9, 32'd8, 5'd11, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_z !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL beq_differ: v=%b z=%b err=%b, required v=1 z=0 err=0", out_valid, out_z, out_err);
        end
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 7'h02, 32'd3, 32'd3, 5'd12, 1'b0, 1'b0);
        tick();
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'h00, 32'd1, 32'd1, 5'd13, 1'b1, 1'b0);
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_mul_idle: rdy=%b at t3, required 1", in_ready);
        end
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 4; i <= 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_valid_t%0d: v=%b, required 0", i, out_valid);
            end
        end
        drive(1'b1, 7'h00, 32'd4, 32'd4, 5'd14, 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_offer: v=%b, required 0", out_valid);
        end
        drive(1'b1, 7'h00, 32'd4, 32'd4, 5'd15, 1'b0, 1'b1);
        tick();
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_w !== 32'd8) begin
            errors++;
            $display("FAIL flush_due_emit: v=%b w=%h, required v=1 w=00000008", out_valid, out_w);
        end
        tick();
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_unknown_and_reset();
        drive(1'b1, 7'h7F, 32'd1, 32'd2, 5'd16, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL unknown_op: v=%b err=%b, required v=1 err=1", out_valid, out_err);
        end
        drive(1'b1, 7'h02, 32'd5, 32'd5, 5'd17, 1'b0, 1'b1);
        tick();
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({out_valid, out_w, out_z, out_rd, out_err, in_ready} !== {1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_mul: v=%b w=%h z=%b rd=%0d err=%b rdy=%b, required zeros with rdy=1",
                     out_valid, out_w, out_z, out_rd, out_err, in_ready);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        checks++;
        if (out_w !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_late: w=%h rdy=%b, required w=0 rdy=1", out_w, in_ready);
        end
    endtask

`ifdef ALU_ISSUE_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        checks++;
        if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: ops=%0d stall=%0d, required 0 0", perf_ops, perf_stall);
        end
        drive(1'b1, 7'h00, 32'd1, 32'd1, 5'd1, 1'b0, 1'b1); tick();
        drive(1'b1, 7'h00, 32'd2, 32'd2, 5'd2, 1'b0, 1'b1); tick();
        drive(1'b1, 7'h00, 32'd3, 32'd3, 5'd3, 1'b0, 1'b1); tick();
        drive(1'b1, 7'h02, 32'd2, 32'd3, 5'd4, 1'b0, 1'b1); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 7'h00, 32'd9, 32'd9, 5'd5, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        checks++;
        if (perf_ops !== 32'd4 || perf_stall !== 32'd4) begin
            errors++;
            $display("FAIL perf_counts: ops=%0d stall=%0d, required 4 4", perf_ops, perf_stall);
        end
    endtask
`endif

    task automatic test_mul_lat1();
        drive(1'b0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        v1 = 1'b1; op1 = 7'h02; x1 = 32'h0001_0000; y1 = 32'h0001_0000; rd1 = 5'd7;
        tick();
        checks++;
        if (o1_valid !== 1'b1 || o1_w !== 32'd0 || o1_rd !== 5'd7 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL lat1_mul_wrap: v=%b w=%h rd=%0d rdy=%b, required v=1 w=0 rd=7 rdy=1", o1_valid, o1_w, o1_rd, rdy1);
        end
        x1 = 32'd3; y1 = 32'd4; rd1 = 5'd8;
        tick();
        checks++;
        if (o1_valid !== 1'b1 || o1_w !== 32'd12 || o1_rd !== 5'd8) begin
            errors++;
            $display("FAIL lat1_mul_b2b: v=%b w=%h rd=%0d, required v=1 w=0000000c rd=8", o1_valid, o1_w, o1_rd);
        end
        v1 = 1'b0;
        tick();
        checks++;
        if (o1_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat1_idle: v=%b, required 0", o1_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_beq();
        test_flush();
        test_unknown_and_reset();
`ifdef ALU_ISSUE_PERF_EN
        test_perf();
`endif
        test_mul_lat1();
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
